// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    // Default operand / result width
    localparam int unsigned DEF_WIDTH = 8;

    // Step counter width: holds WIDTH-1 down to 0, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the divider: operands and start in, results and status out.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    // Requester side
    modport master (
        output start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    // Divider side
    modport slave (
        input  start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivByZero
    );

endinterface

// File: rtl/borrow_sub.sv
// Ripple-borrow subtractor: Diff = a - b, Borrow set when a < b (unsigned).
// Built from a chain of full-subtractor cells; purely combinational.
module borrow_sub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] Diff,
    output logic         Borrow
);

    // bw[i] is the borrow into cell i; bw[N] is the borrow out of the MSB
    logic [N:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        // Full subtractor: difference bit and borrow propagate/generate
        assign Diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign Borrow = bw[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Operands are captured on an accepted start in IDLE; results are held until the next
// completion. A zero divisor completes after a single ZERO cycle with a saturated quotient.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;        // partial remainder
    logic [WIDTH-1:0] d_q, d_d;        // dividend shift register
    logic [WIDTH-1:0] q_q, q_d;        // quotient shift register
    logic [WIDTH-1:0] v_q, v_d;        // divisor
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_r_msb;

    // Trial value: remainder shifted left with the next dividend bit brought down
    assign trial = {r_q[WIDTH-1:0], d_q[WIDTH-1]};

    // The remainder stays below the divisor, so its MSB only carries headroom for the subtract
    assign unused_r_msb = r_q[WIDTH];

    borrow_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .a      (trial),
        .b      ({1'b0, v_q}),
        .Diff   (diff),
        .Borrow (borrow)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        v_d     = v_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    d_d     = bus.Dividend;
                    v_d     = bus.Divisor;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = (bus.Divisor == '0) ? ZERO : RUN;
                end
            end

            RUN: begin
                // Restore on borrow: keep the trial value and shift in a 0
                r_d   = borrow ? trial : diff;
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                d_d   = {d_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    quo_d   = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ZERO: begin
                // d_q has not been shifted, so it still holds the captured dividend
                state_d = IDLE;
                quo_d   = '1;
                rem_d   = d_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            v_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            v_q     <= v_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.Quotient  = quo_q;
    assign bus.Remainder = rem_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider (WIDTH=8) with a result scoreboard.
module tb_seq_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(
        .WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t m;
        if (b == 8'd0) begin
            m.q = 8'hFF; m.r = a; m.z = 1'b1; m.lat = 1;
        end else begin
            m.q = a / b; m.r = a % b; m.z = 1'b0; m.lat = 8;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for Done, counting cycles and Busy cycles since the capture edge
    task automatic wait_done(input int intrude, input bit noise, output int lat,
                             output int busy_n);
        lat = 0;
        busy_n = 0;
        while (bus.Done !== 1'b1 && lat < 40) begin
            if (bus.Busy === 1'b1) busy_n++;
            if (lat == intrude) begin
                bus.start = 1'b1; bus.Dividend = 8'd9; bus.Divisor = 8'd9;
            end else if (noise) begin
                bus.start = 1'b0;
                bus.Dividend = 8'($urandom);
                bus.Divisor = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic compare_done(input string tag, input int lat, input int busy_n,
                                output exp_t e);
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{q: 8'h00, r: 8'h00, z: 1'b0, lat: 0};
        check({tag, "_quo"}, 32'(bus.Quotient), 32'(e.q));
        check({tag, "_rem"}, 32'(bus.Remainder), 32'(e.r));
        check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(e.z));
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(e.lat));
        check({tag, "_busy_end"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int intrude);
        exp_t e;
        int   lat;
        int   busy_n;
        @(negedge clk);
        bus.start = 1'b1; bus.Dividend = a; bus.Divisor = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        wait_done(intrude, 1'b1, lat, busy_n);
        bus.start = 1'b0;
        compare_done(tag, lat, busy_n, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        check({tag, "_hold_quo"}, 32'(bus.Quotient), 32'(e.q));
        check({tag, "_hold_rem"}, 32'(bus.Remainder), 32'(e.r));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        check({tag, "_done"}, 32'(bus.Done), 32'd0);
        check({tag, "_quo"}, 32'(bus.Quotient), 32'd0);
        check({tag, "_rem"}, 32'(bus.Remainder), 32'd0);
        check({tag, "_dbz"}, 32'(bus.DivByZero), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        int   busy_n;
        int   done_seen;
        logic [7:0] a;
        logic [7:0] b;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.Dividend = '0;
        bus.Divisor = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        do_op("div100_7", 8'd100, 8'd7, -1);
        do_op("div255_1", 8'd255, 8'd1, -1);
        do_op("div5_9", 8'd5, 8'd9, -1);
        do_op("div42_0", 8'd42, 8'd0, -1);
        // start with 9/9 sampled at E0+3 while busy must be ignored
        do_op("busy_start", 8'd200, 8'd3, 2);

        // Abort 100/7 by asserting rst sampled at E0+4
        @(negedge clk);
        bus.start = 1'b1; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.Done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        do_op("div17_4", 8'd17, 8'd4, -1);

        // Back-to-back: start held high, new operands accepted in the Done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
        sb.push_back(model(8'd100, 8'd7));
        @(negedge clk);
        bus.Dividend = 8'd250; bus.Divisor = 8'd16;
        sb.push_back(model(8'd250, 8'd16));
        wait_done(-1, 1'b0, lat, busy_n);
        compare_done("b2b_first", lat, busy_n, e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(-1, 1'b1, lat, busy_n);
        compare_done("b2b_second", lat, busy_n, e);

        // Random sweep, including a share of zero divisors
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            do_op("rand", a, b, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
